// File: rtl/sos_gen_if.sv
// SOS enable/indication bundle between the trigger-control side and the SOS pattern generator.
interface sos_gen_if;
    logic SOS_En_Sig;
    logic Pin_Out;
    logic Busy_Sig;
    logic Done_Sig;

    modport master (
        output SOS_En_Sig,
        input  Pin_Out,
        input  Busy_Sig,
        input  Done_Sig
    );

    modport slave (
        input  SOS_En_Sig,
        output Pin_Out,
        output Busy_Sig,
        output Done_Sig
    );
endinterface

// File: rtl/sos_gen_module.sv
// Plays one Morse "SOS" (dot dot dot, dash dash dash, dot dot dot) on an active-low buzzer pin
// per accepted start request, with busy and one-cycle done indications.
module sos_gen_module #(
    parameter int T_1MS         = 50000,
    parameter int DOT_MS        = 100,
    parameter int DASH_MS       = 300,
    parameter int GAP_MS        = 100,
    parameter int LETTER_GAP_MS = 300
) (
    input  logic      CLK,
    input  logic      RSTn,
    sos_gen_if.slave  sos_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TONE    = 2'd1,
        SILENCE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] T_LAST      = 16'(T_1MS - 1);
    localparam logic [15:0] DOT_LAST    = 16'(DOT_MS - 1);
    localparam logic [15:0] DASH_LAST   = 16'(DASH_MS - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_MS - 1);
    localparam logic [15:0] LETTER_LAST = 16'(LETTER_GAP_MS - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] pre_q, pre_d;
    logic [15:0] dur_q, dur_d;
    logic        pin_q, pin_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        tick_s;
    logic [15:0] phase_last_s;
    logic        phase_end_s;

    // Next-state, counter and output computation; counters restart on every phase entry.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pre_d        = pre_q;
        dur_d        = dur_q;
        phase_last_s = 16'd0;
        tick_s       = (pre_q == T_LAST);

        case (state_q)
            TONE: begin
                if (idx_q >= 4'd3 && idx_q <= 4'd5) begin
                    phase_last_s = DASH_LAST;
                end else begin
                    phase_last_s = DOT_LAST;
                end
            end
            SILENCE: begin
                if (idx_q == 4'd2 || idx_q == 4'd5) begin
                    phase_last_s = LETTER_LAST;
                end else begin
                    phase_last_s = GAP_LAST;
                end
            end
            default: begin
                phase_last_s = 16'd0;
            end
        endcase

        phase_end_s = tick_s && (dur_q == phase_last_s);

        case (state_q)
            IDLE: begin
                if (sos_if.SOS_En_Sig) begin
                    state_d = TONE;
                    idx_d   = 4'd0;
                    pre_d   = 16'd0;
                    dur_d   = 16'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            TONE, SILENCE: begin
                if (phase_end_s) begin
                    pre_d = 16'd0;
                    dur_d = 16'd0;
                    if (state_q == SILENCE) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = TONE;
                    end else if (idx_q == 4'd8) begin
                        state_d = DONE;
                    end else begin
                        state_d = SILENCE;
                    end
                end else if (tick_s) begin
                    pre_d = 16'd0;
                    dur_d = dur_q + 16'd1;
                end else begin
                    pre_d = pre_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are visible the cycle after the edge.
        pin_d  = (state_d != TONE);
        busy_d = (state_d == TONE) || (state_d == SILENCE);
        done_d = (state_d == DONE);
    end

    // State, counter and registered-output flops with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            pre_q   <= 16'd0;
            dur_q   <= 16'd0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            dur_q   <= dur_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sos_if.Pin_Out  = pin_q;
    assign sos_if.Busy_Sig = busy_q;
    assign sos_if.Done_Sig = done_q;

endmodule
